wb_arbiter: RTL and testbench

- Writeback-stage arbiter feeding the decode-stage register file's single write port (regwrite/wreg/wdata).
- Accepts results from two producers: ALU pipe (A) and load/memory pipe (M). Each producer has a valid/ready handshake and a private FIFO.
- Each cycle, retires at most one result into the register file, oldest first by sequence tag.
- Drives a busy flag that the decode hazard logic uses.

---
 rtl/wb_arbiter_if.sv | 40 ++++
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two producer handshakes (ALU and
// load pipes) plus the register-file write port and the hazard busy flag.
// The master side is whoever drives the producers and observes the write
// port; the slave side is the arbiter itself.
interface wb_arbiter_if #(
    parameter int REG_ADDR = 5,
    parameter int REG_SIZE = 32,
    parameter int SEQ_W    = 4
);
    logic                a_valid;
    logic                a_ready;
    logic [REG_ADDR-1:0] a_reg;
    logic [REG_SIZE-1:0] a_data;
    logic [SEQ_W-1:0]    a_seq;

    logic                m_valid;
    logic                m_ready;
    logic [REG_ADDR-1:0] m_reg;
    logic [REG_SIZE-1:0] m_data;
    logic [SEQ_W-1:0]    m_seq;

    logic                regwrite;
    logic [REG_ADDR-1:0] wreg;
    logic [REG_SIZE-1:0] wdata;
    logic                busy;

    modport master (
        output a_valid, a_reg, a_data, a_seq,
        output m_valid, m_reg, m_data, m_seq,
        input  a_ready, m_ready,
        input  regwrite, wreg, wdata, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data, a_seq,
        input  m_valid, m_reg, m_data, m_seq,
        output a_ready, m_ready,
        output regwrite, wreg, wdata, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU and load results in private FIFOs and
// retires at most one per cycle into the register file write port,
// oldest sequence tag first. Writes to register 0 are consumed silently.
module wb_arbiter #(
    parameter int REG_ADDR = 5,
    parameter int REG_SIZE = 32,
    parameter int DEPTH    = 4,
    parameter int SEQ_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [REG_ADDR-1:0] rd;
        logic [REG_SIZE-1:0] data;
        logic [SEQ_W-1:0]    seq;
    } entry_t;

    entry_t a_mem [DEPTH];
    entry_t m_mem [DEPTH];

    logic [PW-1:0] a_wr_ptr, a_rd_ptr, m_wr_ptr, m_rd_ptr;
    logic [CW-1:0] a_count, m_count;

    logic a_ready_i, m_ready_i;
    logic a_push, m_push;
    logic a_pop, m_pop;
    logic a_nonempty, m_nonempty;

    entry_t a_in, m_in, a_head, m_head;
    logic [SEQ_W-1:0] seq_diff;
    logic a_older;

    logic [REG_ADDR-1:0] sel_reg;
    logic [REG_SIZE-1:0] sel_data;

    logic                regwrite_q;
    logic [REG_ADDR-1:0] wreg_q;
    logic [REG_SIZE-1:0] wdata_q;

    // Ready looks only at the registered count so it never depends on a pop
    // happening in the same cycle; held low while reset is asserted.
    assign a_ready_i = !rst && (a_count < FULL);
    assign m_ready_i = !rst && (m_count < FULL);
    assign a_push    = bus.a_valid && a_ready_i;
    assign m_push    = bus.m_valid && m_ready_i;

    assign a_in = '{rd: bus.a_reg, data: bus.a_data, seq: bus.a_seq};
    assign m_in = '{rd: bus.m_reg, data: bus.m_data, seq: bus.m_seq};

    assign a_nonempty = (a_count != '0);
    assign m_nonempty = (m_count != '0);
    assign a_head     = a_mem[a_rd_ptr];
    assign m_head     = m_mem[m_rd_ptr];

    // Modular tag distance: A is older when M's tag lies strictly ahead of it
    // within half the tag space. Equal tags go to M.
    assign seq_diff = m_head.seq - a_head.seq;
    assign a_older  = (seq_diff != '0) && !seq_diff[SEQ_W-1];

    // Pick the single head to retire this cycle.
    always_comb begin
        a_pop = 1'b0;
        m_pop = 1'b0;
        if (a_nonempty && (!m_nonempty || a_older)) begin
            a_pop = 1'b1;
        end else if (m_nonempty) begin
            m_pop = 1'b1;
        end
        sel_reg  = a_pop ? a_head.rd   : m_head.rd;
        sel_data = a_pop ? a_head.data : m_head.data;
    end

    // ALU FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (a_push) begin
            a_mem[a_wr_ptr] <= a_in;
        end
    end

    // Load FIFO storage.
    always_ff @(posedge clk) begin
        if (m_push) begin
            m_mem[m_wr_ptr] <= m_in;
        end
    end

    // ALU FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_wr_ptr <= '0;
            a_rd_ptr <= '0;
            a_count  <= '0;
        end else begin
            if (a_push) begin
                a_wr_ptr <= a_wr_ptr + 1'b1;
            end
            if (a_pop) begin
                a_rd_ptr <= a_rd_ptr + 1'b1;
            end
            case ({a_push, a_pop})
                2'b10:   a_count <= a_count + 1'b1;
                2'b01:   a_count <= a_count - 1'b1;
                default: a_count <= a_count;
            endcase
        end
    end

    // Load FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wr_ptr <= '0;
            m_rd_ptr <= '0;
            m_count  <= '0;
        end else begin
            if (m_push) begin
                m_wr_ptr <= m_wr_ptr + 1'b1;
            end
            if (m_pop) begin
                m_rd_ptr <= m_rd_ptr + 1'b1;
            end
            case ({m_push, m_pop})
                2'b10:   m_count <= m_count + 1'b1;
                2'b01:   m_count <= m_count - 1'b1;
                default: m_count <= m_count;
            endcase
        end
    end

    // Register the retired entry; register 0 is consumed without a write and
    // address/data hold when nothing retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else if (a_pop || m_pop) begin
            regwrite_q <= (sel_reg != '0);
            wreg_q     <= sel_reg;
            wdata_q    <= sel_data;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    assign bus.a_ready  = a_ready_i;
    assign bus.m_ready  = m_ready_i;
    assign bus.regwrite = regwrite_q;
    assign bus.wreg     = wreg_q;
    assign bus.wdata    = wdata_q;
    assign bus.busy     = a_nonempty || m_nonempty || regwrite_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, tag ordering with wrap,
// FIFO full back-pressure, register-0 drop and reset mid-stream.
module tb_wb_arbiter;
    localparam int REG_ADDR = 5;
    localparam int REG_SIZE = 32;
    localparam int DEPTH    = 4;
    localparam int SEQ_W    = 4;

    logic clk;
    logic rst;
    int   num_checks = 0;
    int   num_fails  = 0;

    wb_arbiter_if #(.REG_ADDR(REG_ADDR), .REG_SIZE(REG_SIZE), .SEQ_W(SEQ_W)) bus ();

    wb_arbiter #(
        .REG_ADDR(REG_ADDR),
        .REG_SIZE(REG_SIZE),
        .DEPTH   (DEPTH),
        .SEQ_W   (SEQ_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_v, input logic [4:0] a_r,
                                 input logic [31:0] a_d, input logic [3:0] a_s,
                                 input logic m_v, input logic [4:0] m_r,
                                 input logic [31:0] m_d, input logic [3:0] m_s);
        bus.a_valid = a_v;
        bus.a_reg   = a_r;
        bus.a_data  = a_d;
        bus.a_seq   = a_s;
        bus.m_valid = m_v;
        bus.m_reg   = m_r;
        bus.m_data  = m_d;
        bus.m_seq   = m_s;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic we,
                              input logic [4:0] rd, input logic [31:0] data);
        checkOutput({tag, "_regwrite"}, 64'(bus.regwrite), 64'(we));
        checkOutput({tag, "_wreg"},     64'(bus.wreg),     64'(rd));
        checkOutput({tag, "_wdata"},    64'(bus.wdata),    64'(data));
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Reset pulse in the middle of a cycle, no valids.
        #3 rst = 1'b1;
        #1;
        checkWrite("rst", 1'b0, 5'd0, 32'd0);
        checkOutput("rst_busy",    64'(bus.busy),    64'd0);
        checkOutput("rst_a_ready", 64'(bus.a_ready), 64'd0);
        checkOutput("rst_m_ready", 64'(bus.m_ready), 64'd0);
        #8 rst = 1'b0;
        step();
        checkOutput("idle_a_ready", 64'(bus.a_ready), 64'd1);
        checkOutput("idle_m_ready", 64'(bus.m_ready), 64'd1);
        checkOutput("idle_busy",    64'(bus.busy),    64'd0);
        checkOutput("idle_regwrite", 64'(bus.regwrite), 64'd0);

        // Single ALU write: visible two edges after the push.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
        step();
        idle();
        checkOutput("single_busy_fifo", 64'(bus.busy), 64'd1);
        checkOutput("single_early",     64'(bus.regwrite), 64'd0);
        step();
        checkWrite("single", 1'b1, 5'd5, 32'hDEADBEEF);
        checkOutput("single_busy_out", 64'(bus.busy), 64'd1);
        step();
        checkWrite("single_hold", 1'b0, 5'd5, 32'hDEADBEEF);
        checkOutput("single_busy_done", 64'(bus.busy), 64'd0);

        // Ordering: M tag 1 is older than A tag 2.
        applyStimulus(1'b1, 5'd7, 32'd1, 4'd2, 1'b1, 5'd7, 32'd2, 4'd1);
        step();
        idle();
        step();
        checkWrite("order_first", 1'b1, 5'd7, 32'd2);
        step();
        checkWrite("order_second", 1'b1, 5'd7, 32'd1);
        step();
        checkOutput("order_done", 64'(bus.regwrite), 64'd0);

        // Ordering across tag wrap: A tag 15 is older than M tag 0.
        applyStimulus(1'b1, 5'd7, 32'd1, 4'd15, 1'b1, 5'd7, 32'd2, 4'd0);
        step();
        idle();
        step();
        checkWrite("wrap_first", 1'b1, 5'd7, 32'd1);
        step();
        checkWrite("wrap_second", 1'b1, 5'd7, 32'd2);
        step();
        checkOutput("wrap_done", 64'(bus.regwrite), 64'd0);

        // Full: A streams older tags 1..3 and wins every pop, so four M pushes
        // (tags 4..7, data 10..13) pile up and M stops accepting.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k < 3, 5'd1, 32'(31 + k), 4'(1 + k),
                          1'b1, 5'd3, 32'(10 + k), 4'(4 + k));
            step();
            if (k == 0) begin
                checkOutput("full_first", 64'(bus.regwrite), 64'd0);
            end else begin
                checkWrite($sformatf("full_a%0d", k), 1'b1, 5'd1, 32'(30 + k));
            end
        end
        checkOutput("full_m_ready", 64'(bus.m_ready), 64'd0);
        checkOutput("full_a_ready", 64'(bus.a_ready), 64'd1);
        // Producer holds a fifth entry while refused; it lands one edge later.
        applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd3, 32'd14, 4'd8);
        step();
        checkWrite("full_m10", 1'b1, 5'd3, 32'd10);
        checkOutput("full_m_ready_again", 64'(bus.m_ready), 64'd1);
        step();
        idle();
        checkWrite("full_m11", 1'b1, 5'd3, 32'd11);
        for (int k = 12; k <= 14; k++) begin
            step();
            checkWrite($sformatf("full_m%0d", k), 1'b1, 5'd3, 32'(k));
        end
        step();
        checkOutput("full_done_regwrite", 64'(bus.regwrite), 64'd0);
        checkOutput("full_done_busy",     64'(bus.busy),     64'd0);

        // Register 0 entry is consumed without a write.
        applyStimulus(1'b1, 5'd0, 32'hFF, 4'd4, 1'b0, 5'd0, 32'd0, 4'd0);
        step();
        applyStimulus(1'b1, 5'd2, 32'd5, 4'd5, 1'b0, 5'd0, 32'd0, 4'd0);
        step();
        idle();
        checkWrite("r0_drop", 1'b0, 5'd0, 32'hFF);
        checkOutput("r0_busy", 64'(bus.busy), 64'd1);
        step();
        checkWrite("r0_next", 1'b1, 5'd2, 32'd5);
        step();
        checkOutput("r0_done", 64'(bus.regwrite), 64'd0);

        // Reset mid-stream with three entries buffered and one retiring.
        applyStimulus(1'b1, 5'd4, 32'd40, 4'd1, 1'b1, 5'd4, 32'd41, 4'd2);
        step();
        applyStimulus(1'b1, 5'd4, 32'd42, 4'd3, 1'b1, 5'd4, 32'd43, 4'd4);
        step();
        idle();
        checkWrite("mid_pre", 1'b1, 5'd4, 32'd40);
        #2 rst = 1'b1;
        #1;
        checkWrite("mid_rst", 1'b0, 5'd0, 32'd0);
        checkOutput("mid_rst_busy",    64'(bus.busy),    64'd0);
        checkOutput("mid_rst_a_ready", 64'(bus.a_ready), 64'd0);
        #4 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput($sformatf("mid_after%0d_regwrite", k), 64'(bus.regwrite), 64'd0);
            checkOutput($sformatf("mid_after%0d_busy", k),     64'(bus.busy),     64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end
endmodule
